// File: rtl/uart_wb_initiator.sv
// Wishbone initiator for the uart_top register slave: one byte-wide command in,
// one Wishbone cycle out, one response back (read byte or timeout error).
module uart_wb_initiator #(
    parameter int ADDR_W  = 5,
    parameter int TMO_CYC = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_we_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [7:0]        cmd_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [7:0]        rsp_rdata_o,
    output logic              rsp_err_o,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [31:0]       wb_dat_o,
    input  logic [31:0]       wb_dat_i,
    output logic              wb_we_o,
    output logic              wb_stb_o,
    output logic              wb_cyc_o,
    output logic [3:0]        wb_sel_o,
    input  logic              wb_ack_i
);

    localparam int CNT_W = $clog2(TMO_CYC + 1);

    // state  | meaning
    // S_IDLE | ready for a command, bus idle
    // S_BUS  | strobe asserted, waiting for ack or timeout
    // S_RESP | response presented, waiting for rsp_ready_i
    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

    state_t            r_state, w_state_nxt;
    logic              r_cmd_ready, w_cmd_ready_nxt;
    logic              r_rsp_valid, w_rsp_valid_nxt;
    logic [7:0]        r_rsp_rdata, w_rsp_rdata_nxt;
    logic              r_rsp_err, w_rsp_err_nxt;
    logic [ADDR_W-1:0] r_wb_adr, w_wb_adr_nxt;
    logic [31:0]       r_wb_dat, w_wb_dat_nxt;
    logic              r_wb_we, w_wb_we_nxt;
    logic              r_wb_stb, w_wb_stb_nxt;
    logic [3:0]        r_wb_sel, w_wb_sel_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [7:0]        w_lane;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_wb_adr    <= '0;
            r_wb_dat    <= '0;
            r_wb_we     <= 1'b0;
            r_wb_stb    <= 1'b0;
            r_wb_sel    <= '0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd_ready <= w_cmd_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_wb_adr    <= w_wb_adr_nxt;
            r_wb_dat    <= w_wb_dat_nxt;
            r_wb_we     <= w_wb_we_nxt;
            r_wb_stb    <= w_wb_stb_nxt;
            r_wb_sel    <= w_wb_sel_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    // Read byte comes from the lane selected by the low address bits.
    always_comb begin
        w_lane = wb_dat_i[7:0];
        case (r_wb_adr[1:0])
            2'd0: w_lane = wb_dat_i[7:0];
            2'd1: w_lane = wb_dat_i[15:8];
            2'd2: w_lane = wb_dat_i[23:16];
            2'd3: w_lane = wb_dat_i[31:24];
        endcase
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cmd_ready_nxt = r_cmd_ready;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;
        w_wb_adr_nxt    = r_wb_adr;
        w_wb_dat_nxt    = r_wb_dat;
        w_wb_we_nxt     = r_wb_we;
        w_wb_stb_nxt    = r_wb_stb;
        w_wb_sel_nxt    = r_wb_sel;
        w_cnt_nxt       = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    w_wb_adr_nxt    = cmd_addr_i;
                    w_wb_dat_nxt    = {4{cmd_wdata_i}};
                    w_wb_we_nxt     = cmd_we_i;
                    w_wb_sel_nxt    = 4'b0001 << cmd_addr_i[1:0];
                    w_wb_stb_nxt    = 1'b1;
                    w_cmd_ready_nxt = 1'b0;
                    w_cnt_nxt       = '0;
                    w_state_nxt     = S_BUS;
                end
            end
            S_BUS: begin
                // Ack is checked first so it wins over a coincident timeout.
                if (wb_ack_i || (r_cnt == CNT_W'(TMO_CYC - 1))) begin
                    w_rsp_rdata_nxt = (wb_ack_i && !r_wb_we) ? w_lane : 8'h00;
                    w_rsp_err_nxt   = !wb_ack_i;
                    w_rsp_valid_nxt = 1'b1;
                    w_wb_adr_nxt    = '0;
                    w_wb_dat_nxt    = '0;
                    w_wb_we_nxt     = 1'b0;
                    w_wb_stb_nxt    = 1'b0;
                    w_wb_sel_nxt    = '0;
                    w_state_nxt     = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_rsp_rdata_nxt = 8'h00;
                    w_rsp_err_nxt   = 1'b0;
                    w_cmd_ready_nxt = 1'b1;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign cmd_ready_o = r_cmd_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_rdata_o = r_rsp_rdata;
    assign rsp_err_o   = r_rsp_err;
    assign wb_adr_o    = r_wb_adr;
    assign wb_dat_o    = r_wb_dat;
    assign wb_we_o     = r_wb_we;
    assign wb_stb_o    = r_wb_stb;
    assign wb_cyc_o    = r_wb_stb;
    assign wb_sel_o    = r_wb_sel;

endmodule
